// File: rtl/sdram_port_scheduler.sv
// Round-robin burst scheduler for two write FIFOs and two read FIFOs sharing one SDRAM controller.
// Each port walks its own address region in BURST_LENGTH steps; one burst request is outstanding at a time.

module sdram_port_offset #(
   parameter int BURST_LENGTH = 8,
   parameter int REGION_WORDS = 1024,
   parameter int OW           = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          lock,
   input  logic          adv,
   input  logic          frame_rst,
   output logic [OW-1:0] offset
);
   logic          pend;
   logic [OW-1:0] nxt;

   assign nxt = (offset == OW'(REGION_WORDS - BURST_LENGTH)) ? '0 : offset + OW'(BURST_LENGTH);

   // While this port owns the request, a frame restart is deferred so the ack cannot re-advance it.
   always_ff @(posedge clk) begin
      if (rst) begin
         offset <= '0;
         pend   <= 1'b0;
      end else if (lock) begin
         if (adv) begin
            offset <= (pend || frame_rst) ? '0 : nxt;
            pend   <= 1'b0;
         end else begin
            pend   <= pend | frame_rst;
         end
      end else if (pend || frame_rst) begin
         offset <= '0;
         pend   <= 1'b0;
      end
   end
endmodule

module sdram_port_scheduler #(
   parameter int          BURST_LENGTH = 8,
   parameter int          REGION_WORDS = 1024,
   parameter logic [21:0] BASE0        = 22'h000000,
   parameter logic [21:0] BASE1        = 22'h100000,
   parameter logic [21:0] BASE2        = 22'h200000,
   parameter logic [21:0] BASE3        = 22'h300000,
   parameter int          RD_THRESH    = 16,
   parameter int          ACK_TIMEOUT  = 4095
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sdram_init_done,
   input  logic [1:0]  ctrl_cmd,
   input  logic        cmd_ack,
   input  logic [3:0]  port_en,
   input  logic [10:0] wp0_level,
   input  logic [10:0] wp1_level,
   input  logic [10:0] rp0_level,
   input  logic [10:0] rp1_level,
   input  logic [1:0]  rd_arm,
   input  logic [3:0]  frame_rst,
   output logic        sys_w_req,
   output logic        sys_r_req,
   output logic [21:0] sys_wr_addr,
   output logic [3:0]  done,
   output logic        busy,
   output logic        err
);
   localparam int OW = $clog2(REGION_WORDS);
   localparam int CW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [3:0][21:0] BASES = {BASE3, BASE2, BASE1, BASE0};

   typedef enum logic [1:0] {IDLE, ARB, REQ, HOLD} state_t;

   state_t               state, state_nxt;
   logic [3:0]           elig;
   logic [3:0][OW-1:0]   offs;
   logic [1:0]           rr_ptr, grant_q, arb_idx, cand;
   logic                 arb_found;
   logic [21:0]          addr_q;
   logic [CW-1:0]        cnt;
   logic [3:0]           done_q;
   logic                 err_q;
   logic                 ack_fire, timeout, to_fire;

   assign elig[0] = port_en[0] && (wp0_level >= 11'(BURST_LENGTH));
   assign elig[1] = port_en[1] && (wp1_level >= 11'(BURST_LENGTH));
   assign elig[2] = port_en[2] && rd_arm[0] && (rp0_level <= 11'(RD_THRESH));
   assign elig[3] = port_en[3] && rd_arm[1] && (rp1_level <= 11'(RD_THRESH));

   assign ack_fire = (state == REQ) && sdram_init_done && cmd_ack;
   assign timeout  = (cnt == CW'(ACK_TIMEOUT - 1));
   assign to_fire  = (state == REQ) && sdram_init_done && !cmd_ack && timeout;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_port
         sdram_port_offset #(
            .BURST_LENGTH (BURST_LENGTH),
            .REGION_WORDS (REGION_WORDS),
            .OW           (OW)
         ) u_off (
            .clk       (clk),
            .rst       (rst),
            .lock      ((state == REQ) && (grant_q == 2'(gi))),
            .adv       (ack_fire && (grant_q == 2'(gi))),
            .frame_rst (frame_rst[gi]),
            .offset    (offs[gi])
         );
      end
   endgenerate

   // Scan starts one past the last acknowledged port.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = rr_ptr;
      cand      = rr_ptr;
      for (int k = 1; k <= 4; k++) begin
         cand = rr_ptr + 2'(k);
         if (!arb_found && elig[cand]) begin
            arb_found = 1'b1;
            arb_idx   = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (sdram_init_done && ctrl_cmd == 2'b00) state_nxt = ARB;
         ARB:  state_nxt = (sdram_init_done && arb_found) ? REQ : IDLE;
         REQ: begin
            if (!sdram_init_done)  state_nxt = IDLE;
            else if (cmd_ack)      state_nxt = HOLD;
            else if (timeout)      state_nxt = IDLE;
         end
         HOLD: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy        = (state != IDLE);
      sys_w_req   = (state == REQ) && !grant_q[1];
      sys_r_req   = (state == REQ) &&  grant_q[1];
      sys_wr_addr = addr_q;
      done        = done_q;
      err         = err_q;
   end

   // Address is captured at grant so later offset changes never disturb a pending request.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_q <= 2'd0;
         addr_q  <= '0;
         rr_ptr  <= 2'd3;
         cnt     <= '0;
         done_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         if (state == ARB && arb_found && sdram_init_done) begin
            grant_q <= arb_idx;
            addr_q  <= BASES[arb_idx] + 22'(offs[arb_idx]);
         end
         if (ack_fire) rr_ptr <= grant_q;
         if (state == REQ && state_nxt == REQ) cnt <= cnt + 1'b1;
         else                                  cnt <= '0;
         done_q <= ack_fire ? (4'b0001 << grant_q) : 4'b0000;
         if (to_fire) err_q <= 1'b1;
      end
   end
endmodule
